// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe: pipelined W x W unsigned multiplier built from four H x H
// quadrant products (H = W/2), each with its own run-time approximation mode.
// Every result is compared against the exact product. Saturating counters
// record how many results were delivered and how many of them were inexact.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake for a, b, mode
//   a, b                  W-bit unsigned operands
//   mode                  2 bits per quadrant: [1:0] LL, [3:2] LH, [5:4] HL, [7:6] HH
//                         0 exact, 1 clear TRUNC_LO lsbs, 2 clear 2*TRUNC_LO lsbs, 3 zero
//   out_valid / out_ready output handshake for prod, exact_err
//   prod                  2W-bit approximate product
//   exact_err             prod != a*b for this transaction
//   err_cnt, tx_cnt       saturating counters of inexact / delivered results
//   stat_clr              synchronous clear of both counters

// One quadrant: exact H x H product followed by the selected approximation.
module approx_quad #(
    parameter int W        = 8,
    parameter int TRUNC_LO = 2
) (
    input  logic [W/2-1:0] x_i,
    input  logic [W/2-1:0] y_i,
    input  logic [1:0]     mode_i,
    output logic [W-1:0]   p_o
);
    localparam int H = W / 2;
    localparam logic [W-1:0] MASK1 = {W{1'b1}} << TRUNC_LO;
    localparam logic [W-1:0] MASK2 = {W{1'b1}} << (2 * TRUNC_LO);

    logic [W-1:0] full;
    assign full = {{H{1'b0}}, x_i} * {{H{1'b0}}, y_i};

    always_comb begin
        p_o = full;
        case (mode_i)
            2'd0:    p_o = full;
            2'd1:    p_o = full & MASK1;
            2'd2:    p_o = full & MASK2;
            default: p_o = '0;
        endcase
    end
endmodule

module approx_mul_pipe #(
    parameter int W        = 8,
    parameter int TRUNC_LO = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [7:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   prod,
    output logic             exact_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] tx_cnt,
    input  logic             stat_clr
);
    localparam int H = W / 2;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [7:0]   mode;
    } req_t;

    // Stage valids, index = stage number.
    logic [3:1] vld_q;
    logic       rdy1, rdy2, rdy3;

    // A stage may load when it is empty or its contents leave this cycle.
    assign rdy3     = !vld_q[3] || out_ready;
    assign rdy2     = !vld_q[2] || rdy3;
    assign rdy1     = !vld_q[1] || rdy2;
    assign in_ready = rdy1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            if (rdy1) vld_q[1] <= in_valid;
            if (rdy2) vld_q[2] <= vld_q[1];
            if (rdy3) vld_q[3] <= vld_q[2];
        end
    end

    // ---------------- S1: operand capture ----------------
    req_t s1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                s1_q <= '0;
        else if (rdy1 && in_valid) s1_q <= '{a: a, b: b, mode: mode};
    end

    // ---------------- S2: quadrant products + exact reference ----------------
    logic [3:0][H-1:0] qx, qy;
    logic [3:0][W-1:0] pp_d, pp_q;
    logic [2*W-1:0]    exact_d, exact_q;

    // Quadrant order matches the mode field: 0 LL, 1 LH, 2 HL, 3 HH.
    assign qx = {s1_q.a[W-1:H], s1_q.a[W-1:H], s1_q.a[H-1:0], s1_q.a[H-1:0]};
    assign qy = {s1_q.b[W-1:H], s1_q.b[H-1:0], s1_q.b[W-1:H], s1_q.b[H-1:0]};

    for (genvar q = 0; q < 4; q++) begin : g_quad
        approx_quad #(.W(W), .TRUNC_LO(TRUNC_LO)) u_quad (
            .x_i    (qx[q]),
            .y_i    (qy[q]),
            .mode_i (s1_q.mode[2*q +: 2]),
            .p_o    (pp_d[q])
        );
    end

    assign exact_d = {{W{1'b0}}, s1_q.a} * {{W{1'b0}}, s1_q.b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_q    <= '0;
            exact_q <= '0;
        end else if (rdy2 && vld_q[1]) begin
            pp_q    <= pp_d;
            exact_q <= exact_d;
        end
    end

    // ---------------- S3: exact recombination + error flag ----------------
    logic [2*W-1:0] mid, prod_d, prod_q;
    logic           err_d, err_q;

    assign mid    = ({{W{1'b0}}, pp_q[1]} + {{W{1'b0}}, pp_q[2]}) << H;
    assign prod_d = {pp_q[3], {W{1'b0}}} + mid + {{W{1'b0}}, pp_q[0]};
    assign err_d  = (prod_d != exact_q);

    // Loads only with a real transaction so a held or idle output stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            err_q  <= 1'b0;
        end else if (rdy3 && vld_q[2]) begin
            prod_q <= prod_d;
            err_q  <= err_d;
        end
    end

    assign out_valid = vld_q[3];
    assign prod      = prod_q;
    assign exact_err = err_q;

    // ---------------- Statistics ----------------
    logic             deliver;
    logic [CNT_W-1:0] tx_d, tx_q, errc_d, errc_q;

    assign deliver = vld_q[3] && out_ready;

    // Clear wins, but a delivery in the same cycle is still counted.
    always_comb begin
        tx_d   = tx_q;
        errc_d = errc_q;
        if (stat_clr) begin
            tx_d   = deliver ? CNT_ONE : '0;
            errc_d = (deliver && err_q) ? CNT_ONE : '0;
        end else if (deliver) begin
            if (tx_q != CNT_MAX)            tx_d   = tx_q + CNT_ONE;
            if (err_q && errc_q != CNT_MAX) errc_d = errc_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q   <= '0;
            errc_q <= '0;
        end else begin
            tx_q   <= tx_d;
            errc_q <= errc_d;
        end
    end

    assign tx_cnt  = tx_q;
    assign err_cnt = errc_q;
endmodule

// File: tb/tb_approx_mul_pipe.sv
// Directed bench for approx_mul_pipe (W=8, TRUNC_LO=2). A second instance
// with 2-bit counters shares all inputs so counter saturation is reachable.
module tb_approx_mul_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        stat_clr = 1'b0;
    logic [7:0]  a = '0, b = '0, mode = '0;

    logic        in_ready, out_valid, exact_err;
    logic [15:0] prod, err_cnt, tx_cnt;

    logic        s_in_ready, s_out_valid, s_exact_err;
    logic [15:0] s_prod;
    logic [1:0]  s_err_cnt, s_tx_cnt;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    approx_mul_pipe #(.W(8), .TRUNC_LO(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .exact_err(exact_err), .err_cnt(err_cnt), .tx_cnt(tx_cnt),
        .stat_clr(stat_clr)
    );

    approx_mul_pipe #(.W(8), .TRUNC_LO(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(s_out_valid), .out_ready(out_ready),
        .prod(s_prod), .exact_err(s_exact_err), .err_cnt(s_err_cnt), .tx_cnt(s_tx_cnt),
        .stat_clr(stat_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction with out_ready=1; checks latency and result,
    // then lets it be delivered.
    task automatic run_one(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] tm,
                           input logic [15:0] ep, input logic ee, input string tag);
        a = ta; b = tb_; mode = tm; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk({tag, "_lat2_vld"}, out_valid, 0);
        step();
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_prod"}, prod, ep);
        chk({tag, "_err"}, exact_err, ee);
        step();
    endtask

    logic [7:0]  va[5], vb[5], vm[5];
    logic [15:0] vp[5];
    logic        ve[5];

    initial begin
        int k, n;
        logic r, iv, ov, oe;
        logic [15:0] op;

        va = '{8'h12, 8'hFF, 8'hFF, 8'hAB, 8'hFF};
        vb = '{8'h34, 8'hFF, 8'hFF, 8'hCD, 8'hFF};
        vm = '{8'h00, 8'h01, 8'h04, 8'h00, 8'h30};
        vp = '{16'h03A8, 16'hFE00, 16'hFDF1, 16'h88EF, 16'hEFF1};
        ve = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_prod", prod, 0);
        chk("rst_tx", tx_cnt, 0);
        chk("rst_err", err_cnt, 0);
        #5 rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);

        // Single transactions
        run_one(8'hFF, 8'hFF, 8'h00, 16'hFE01, 1'b0, "ff_m00");
        chk("ff_m00_tx", tx_cnt, 1);
        chk("ff_m00_errcnt", err_cnt, 0);
        chk("ff_m00_idle", out_valid, 0);
        run_one(8'hFF, 8'hFF, 8'h01, 16'hFE00, 1'b1, "ff_m01");
        run_one(8'hFF, 8'hFF, 8'h80, 16'hFD01, 1'b1, "ff_m80");
        run_one(8'hFF, 8'hFF, 8'hFF, 16'h0000, 1'b1, "ff_mff");
        chk("single_tx", tx_cnt, 4);
        chk("single_errcnt", err_cnt, 3);

        // Back-to-back stream: result i appears two edges after item i's edge
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin
                a = va[i]; b = vb[i]; mode = vm[i]; in_valid = 1'b1;
                #1 chk("stream_in_ready", in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 2) begin
                chk("stream_vld", out_valid, 1);
                chk("stream_prod", prod, vp[i-2]);
                chk("stream_err", exact_err, ve[i-2]);
            end
        end
        in_valid = 1'b0;
        step();
        chk("stream_tx", tx_cnt, 9);
        chk("stream_errcnt", err_cnt, 6);

        // Backpressure: only three fit while the output is stalled
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            a = va[k]; b = vb[k]; mode = vm[k]; in_valid = 1'b1;
            #1 r = in_ready;
            step();
            if (r) k++;
        end
        #1;
        chk("bp_accepted", k, 3);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_vld", out_valid, 1);
        chk("bp_held_prod", prod, vp[0]);
        step();
        chk("bp_held_prod2", prod, vp[0]);
        chk("bp_held_err", exact_err, ve[0]);

        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 5; c++) begin
            iv = (k < 5);
            in_valid = iv;
            if (iv) begin a = va[k]; b = vb[k]; mode = vm[k]; end
            #1;
            r = in_ready; ov = out_valid; op = prod; oe = exact_err;
            step();
            if (iv && r) k++;
            if (ov) begin
                chk("bp_out_prod", op, vp[n]);
                chk("bp_out_err", oe, ve[n]);
                n++;
            end
        end
        in_valid = 1'b0;
        chk("bp_delivered", n, 5);
        chk("bp_all_accepted", k, 5);
        chk("bp_tx", tx_cnt, 14);
        chk("bp_errcnt", err_cnt, 9);
        chk("sat_tx_pre", s_tx_cnt, 3);
        chk("sat_err_pre", s_err_cnt, 3);

        // stat_clr on a delivery cycle with exact_err=1
        a = 8'hFF; b = 8'hFF; mode = 8'h01; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("clr_vld", out_valid, 1);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("clr_tx", tx_cnt, 1);
        chk("clr_err", err_cnt, 1);
        chk("clr_sat_tx", s_tx_cnt, 1);
        chk("clr_sat_err", s_err_cnt, 1);

        // Saturation of the 2-bit counters
        for (int i = 0; i < 4; i++)
            run_one(8'hFF, 8'hFF, 8'h01, 16'hFE00, 1'b1, "sat");
        chk("sat_err", s_err_cnt, 3);
        chk("sat_tx", s_tx_cnt, 3);
        chk("sat_main_tx", tx_cnt, 5);
        chk("sat_main_err", err_cnt, 5);

        // Asynchronous reset with two transactions in flight
        a = 8'hAB; b = 8'hCD; mode = 8'h00; in_valid = 1'b1;
        step();
        a = 8'h12; b = 8'h34;
        step();
        in_valid = 1'b0;
        chk("inflight_prod_before", prod, 16'hFE00);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", out_valid, 0);
        chk("arst_prod", prod, 0);
        chk("arst_tx", tx_cnt, 0);
        chk("arst_err", err_cnt, 0);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("arst_no_stale", out_valid, 0);
        end
        run_one(8'h12, 8'h34, 8'h00, 16'h03A8, 1'b0, "post_rst");
        chk("post_rst_tx", tx_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/approx_mul_pipe.md
Name: approx_mul_pipe

Overview:
- Parametrised, pipelined successor to the 8x8 four-quadrant approximate multiplier.
- Splits each W-bit unsigned operand into halves and forms four H x H partial products (LL, LH, HL, HH).
- Each quadrant has a run-time approximation mode, selected per transaction; the four quadrants are summed exactly.
- Adds a valid/ready pipeline, a per-result mismatch flag against an exact reference product, and saturating error/transaction counters for on-FPGA error-rate characterisation.

Parameters:
- W, 8: operand width; must be even and >= 4. H = W/2.
- TRUNC_LO, 2: base truncation amount in bits; 2*TRUNC_LO <= W.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept an input this cycle
- a  in  W  unsigned multiplicand
- b  in  W  unsigned multiplier
- mode  in  8  per-quadrant mode: [1:0] LL (al*bl), [3:2] LH (al*bh), [5:4] HL (ah*bl), [7:6] HH (ah*bh)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- prod  out  2W  approximate product
- exact_err  out  1  1 when prod differs from the exact a*b of the same transaction
- err_cnt  out  CNT_W  number of delivered results with exact_err=1
- tx_cnt  out  CNT_W  number of delivered results
- stat_clr  in  1  synchronous clear of err_cnt and tx_cnt

Behaviour:
- Reset (rst_n low, asynchronous): all stage valids, out_valid, prod, exact_err, err_cnt and tx_cnt go to 0. in_ready reads 1 once reset is released. Any transaction in flight is discarded.
- Quadrant product P_q is an exact H x H product (W bits). Mode m selects the approximation:
  - m=0: P_q unchanged.
  - m=1: low TRUNC_LO bits of P_q forced to 0.
  - m=2: low 2*TRUNC_LO bits of P_q forced to 0.
  - m=3: P_q forced to 0 (quadrant bypassed).
- Sum: prod = HH<<W + (LH+HL)<<H + LL, computed at full 2W width with no further approximation. The exact reference is a*b at 2W width.
- Pipeline stages:
  - S1 registers a, b and mode.
  - S2 registers the four approximated partial products and the exact product.
  - S3 registers prod and exact_err.
- Latency: 3 cycles from the in_valid&in_ready edge to out_valid, with no backpressure. Throughput is 1 per cycle.
- Handshake: a stage loads when it is empty or its contents move on the same cycle.
  - in_ready = !S1_valid | S1_advances.
  - S3 holds while out_valid & !out_ready; prod and exact_err stay stable while held.
  - Capacity is 3 transactions. With out_ready held low, in_ready drops after the 3rd accept.
  - mode is captured with its own transaction; changing mode mid-stream affects only later transactions.
- Combinational ready path from out_ready to in_ready is permitted; no combinational path from any input data to any output.
- Statistics: on each out_valid & out_ready cycle, tx_cnt increments by 1, and err_cnt increments by 1 if exact_err=1. Both counters saturate at all-ones.
- stat_clr has priority. If a delivery occurs in the same cycle, the counters load that event's contribution: tx_cnt=1, err_cnt=exact_err.
- Releasing reset mid-stream restarts from empty; no partial result is ever emitted.

Test Plan:
- All directed scenarios use W=8, TRUNC_LO=2.
- a=0xFF, b=0xFF, mode=0x00 -> prod=0xFE01, exact_err=0, 3 cycles after accept; tx_cnt=1, err_cnt=0.
- a=0xFF, b=0xFF, mode=0x01 (LL trunc 2) -> prod=0xFE00, exact_err=1; mode=0x80 (HH trunc 4) -> prod=0xFD01, exact_err=1; mode=0xFF -> prod=0x0000, exact_err=1.
- Back-to-back stream of 5 transactions, each with a different mode and out_ready=1 -> 5 results in consecutive cycles, in order, each matching its own mode; mode changes do not leak between transactions.
- Hold out_ready=0, offer 5 inputs -> exactly 3 accepted, then in_ready=0 and prod held stable; raise out_ready -> remaining 2 accepted, all 5 results delivered in order.
- Preload err_cnt near saturation (or use CNT_W=2) and deliver erroneous results -> counter stops at all-ones. Assert stat_clr on a delivery cycle with exact_err=1 -> err_cnt=1, tx_cnt=1 next cycle.
- Drop rst_n asynchronously with 2 transactions in flight -> out_valid, counters and prod go to 0 immediately. After release, no stale results appear and a fresh 0x12*0x34 with mode=0 yields 0x03A8.
